// File: rtl/branch_predict_pkg.sv
// rtl/branch_predict_pkg.sv - shared branch-type encoding and PResult/BResult records
package branch_predict_pkg;

  typedef enum logic [1:0] {
    BIsNone = 2'd0,
    BIsImme = 2'd1,
    BIsCall = 2'd2,
    BIsRetn = 2'd3
  } btype_e;

  // Prediction travelling down the pipeline with the fetched instruction.
  typedef struct packed {
    logic        Valid;
    logic        Hit;
    btype_e      Type;
    logic [1:0]  Count;
    logic [31:0] Target;
  } presult_t;

  // Resolved outcome returned by EXE for one instruction.
  typedef struct packed {
    logic        Valid;
    logic        Hit;
    btype_e      Type;
    logic        IsTaken;
    logic [31:0] Target;
    logic [31:0] PC;
    logic [1:0]  Count;
    logic        RetnSuccess;
  } bresult_t;

endpackage

// File: rtl/branch_predict_unit.sv
// rtl/branch_predict_unit.sv - fetch-side BTB + 2-bit counters + speculative return stack
//
// Purpose: looks up IF_PC in a direct-mapped BTB, forms a registered PResult
// (next fetch target) and trains the BTB from the EXE BResult stream.
// Ports:
//   clk, rst      clock, synchronous active-high reset
//   IF_Req        fetch PC valid this cycle
//   IF_Stall      hold the registered prediction, no RAS activity
//   IF_Flush      drop the prediction (Valid=0), no RAS activity
//   IF_PC         PC being looked up
//   IF_PResult    registered prediction {Valid, Hit, Type, Count, Target}
//   EXE_BResult   resolved branch outcome used to update the BTB
module branch_predict_unit
  import branch_predict_pkg::*;
#(
  parameter int BTB_IDX_W = 6,
  parameter int RAS_DEPTH = 8
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        IF_Req,
  input  logic        IF_Stall,
  input  logic        IF_Flush,
  input  logic [31:0] IF_PC,
  output presult_t    IF_PResult,
  input  bresult_t    EXE_BResult
);

  localparam int ENTRIES   = 1 << BTB_IDX_W;
  localparam int TAG_W     = 30 - BTB_IDX_W;
  localparam int RAS_PTR_W = $clog2(RAS_DEPTH);
  localparam int RAS_CNT_W = RAS_PTR_W + 1;
  localparam logic [RAS_CNT_W-1:0] RAS_FULL = RAS_CNT_W'(RAS_DEPTH);

  // BTB storage; only the valid bits need a reset.
  logic [ENTRIES-1:0] btb_valid_q;
  logic [TAG_W-1:0]   btb_tag_q [ENTRIES];
  btype_e             btb_type_q[ENTRIES];
  logic [1:0]         btb_cnt_q [ENTRIES];
  logic [31:0]        btb_tgt_q [ENTRIES];

  // Return stack: ras_ptr_q points at the current top entry.
  logic [31:0]          ras_q [RAS_DEPTH];
  logic [RAS_PTR_W-1:0] ras_ptr_q, ras_ptr_d;
  logic [RAS_CNT_W-1:0] ras_cnt_q, ras_cnt_d;

  presult_t presult_q, presult_d;
  presult_t pred;

  logic [BTB_IDX_W-1:0] lk_idx, up_idx;
  logic [TAG_W-1:0]     lk_tag, up_tag;
  logic                 lk_hit;
  logic                 lookup_acc;
  logic [31:0]          pc_plus8;
  logic                 ras_empty;
  logic [31:0]          ras_top;
  logic                 do_push, do_pop;
  logic                 push_en;
  logic                 up_write;
  logic [1:0]           up_cnt;
  logic                 unused_bits;

  assign lk_idx     = IF_PC[BTB_IDX_W+1:2];
  assign lk_tag     = IF_PC[31:BTB_IDX_W+2];
  assign up_idx     = EXE_BResult.PC[BTB_IDX_W+1:2];
  assign up_tag     = EXE_BResult.PC[31:BTB_IDX_W+2];
  assign lk_hit     = btb_valid_q[lk_idx] && (btb_tag_q[lk_idx] == lk_tag);
  assign lookup_acc = IF_Req & ~IF_Stall;
  assign pc_plus8   = IF_PC + 32'd8;
  assign ras_empty  = (ras_cnt_q == '0);
  assign ras_top    = ras_q[ras_ptr_q];
  assign push_en    = lookup_acc & ~IF_Flush & do_push;
  assign up_write   = EXE_BResult.Valid & (EXE_BResult.Type != BIsNone);
  assign unused_bits = ^{IF_PC[1:0], EXE_BResult.PC[1:0], EXE_BResult.RetnSuccess};

  // Prediction from the pre-update array contents (same-edge updates are not seen).
  always_comb begin
    pred        = '0;
    do_push     = 1'b0;
    do_pop      = 1'b0;
    pred.Valid  = 1'b1;
    pred.Hit    = lk_hit;
    pred.Type   = BIsNone;
    pred.Count  = 2'b01;
    pred.Target = pc_plus8;
    if (lk_hit) begin
      pred.Type  = btb_type_q[lk_idx];
      pred.Count = btb_cnt_q[lk_idx];
      case (btb_type_q[lk_idx])
        BIsImme: pred.Target = btb_cnt_q[lk_idx][1] ? btb_tgt_q[lk_idx] : pc_plus8;
        BIsCall: begin
          pred.Target = btb_tgt_q[lk_idx];
          do_push     = 1'b1;
        end
        BIsRetn: begin
          pred.Target = ras_empty ? btb_tgt_q[lk_idx] : ras_top;
          do_pop      = 1'b1;
        end
        default: ;
      endcase
    end
  end

  // Output register and RAS bookkeeping; flush wins over a concurrent lookup.
  always_comb begin
    presult_d = presult_q;
    ras_ptr_d = ras_ptr_q;
    ras_cnt_d = ras_cnt_q;
    if (IF_Flush) begin
      presult_d.Valid = 1'b0;
    end else if (lookup_acc) begin
      presult_d = pred;
      if (do_push) begin
        ras_ptr_d = ras_ptr_q + RAS_PTR_W'(1);
        if (ras_cnt_q != RAS_FULL) ras_cnt_d = ras_cnt_q + RAS_CNT_W'(1);
      end else if (do_pop && !ras_empty) begin
        ras_ptr_d = ras_ptr_q - RAS_PTR_W'(1);
        ras_cnt_d = ras_cnt_q - RAS_CNT_W'(1);
      end
    end
  end

  // Saturating 2-bit counter step based on the count seen at prediction time.
  always_comb begin
    up_cnt = EXE_BResult.Count;
    if (EXE_BResult.IsTaken) begin
      if (EXE_BResult.Count != 2'b11) up_cnt = EXE_BResult.Count + 2'b01;
    end else begin
      if (EXE_BResult.Count != 2'b00) up_cnt = EXE_BResult.Count - 2'b01;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      presult_q   <= '0;
      ras_ptr_q   <= '0;
      ras_cnt_q   <= '0;
      btb_valid_q <= '0;
    end else begin
      presult_q <= presult_d;
      ras_ptr_q <= ras_ptr_d;
      ras_cnt_q <= ras_cnt_d;
      if (EXE_BResult.Valid) begin
        // A hit on a non-branch means the slot aliased: invalidate it.
        if (EXE_BResult.Hit) btb_valid_q[up_idx] <= (EXE_BResult.Type != BIsNone);
        else if (EXE_BResult.Type != BIsNone) btb_valid_q[up_idx] <= 1'b1;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (push_en) ras_q[ras_ptr_d] <= pc_plus8;
    if (up_write) begin
      btb_tag_q[up_idx]  <= up_tag;
      btb_type_q[up_idx] <= EXE_BResult.Type;
      btb_cnt_q[up_idx]  <= EXE_BResult.Hit ? up_cnt
                          : (EXE_BResult.IsTaken ? 2'b10 : 2'b01);
      if (EXE_BResult.IsTaken) btb_tgt_q[up_idx] <= EXE_BResult.Target;
    end
  end

  assign IF_PResult = presult_q;

endmodule
